// File: rtl/store_write_buffer_if.sv
// Store write buffer bus: cache store/load side plus the DRAM side.
// The buffer uses the slave modport; the cache/DRAM environment uses master.
interface store_write_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_valid;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_en;
    logic [WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_hit;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_din;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;
    logic             empty;
    logic [CW-1:0]    count;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_en, rd_addr,
        output rd_data, rd_hit,
        output mem_addr, mem_din, mem_we,
        input  mem_rdata, mem_ready,
        output empty, count
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_en, rd_addr,
        input  rd_data, rd_hit,
        input  mem_addr, mem_din, mem_we,
        output mem_rdata, mem_ready,
        input  empty, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between data cache and DRAM with youngest-store
// load forwarding; owns the DRAM address/write mux.
module store_write_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    store_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    ptr_t            head_q;
    ptr_t            tail_q;
    logic [CW-1:0]   count_q;

    logic             full;
    logic             is_empty;
    logic             push;
    logic             pop;
    logic             hit;
    logic             rd_hit;
    logic             miss_rd;
    logic             we;
    logic [WIDTH-1:0] hit_data;
    entry_t           head_e;

    assign full     = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);
    assign head_e   = mem_q[head_q];

    // No bypass: a full buffer rejects a push even if it pops this cycle.
    assign push = !rst && bus.wr_valid && !full;

    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        ptr_t idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (valid_q[idx] && mem_q[idx].addr == bus.rd_addr) begin
                hit      = 1'b1;
                hit_data = mem_q[idx].data;
            end
        end
    end

    assign rd_hit  = !rst && bus.rd_en && hit;
    assign miss_rd = bus.rd_en && !rd_hit;
    assign we      = !rst && !miss_rd && !is_empty;
    assign pop     = we && bus.mem_ready;

    assign bus.rd_hit   = rd_hit;
    assign bus.rd_data  = rd_hit ? hit_data : bus.mem_rdata;
    assign bus.mem_we   = we;
    assign bus.mem_addr = we ? head_e.addr : bus.rd_addr;
    assign bus.mem_din  = head_e.data;
    assign bus.wr_ready = rst || !full;
    assign bus.empty    = rst || is_empty;
    assign bus.count    = rst ? '0 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail_q          <= tail_q + ptr_t'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + ptr_t'(1);
                valid_q[head_q] <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage is never cleared; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q].addr <= bus.wr_addr;
            mem_q[tail_q].data <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed testbench for store_write_buffer with a small DRAM model
// and an in-order write log.
module tb_store_write_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic dram_clr;
    int   vec;
    int   bad;

    store_write_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    store_write_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0]  dram [0:255];
    logic [255:0] dram_v;
    logic [31:0]  log_a [0:255];
    logic [31:0]  log_d [0:255];
    int           log_n;

    assign bus.mem_rdata = dram_v[bus.mem_addr[9:2]] ?
        dram[bus.mem_addr[9:2]] : (32'hD000_0000 | bus.mem_addr);

    always @(posedge clk) begin
        if (dram_clr) begin
            dram_v <= '0;
            log_n  <= 0;
        end else if (bus.mem_we && bus.mem_ready) begin
            dram[bus.mem_addr[9:2]]   <= bus.mem_din;
            dram_v[bus.mem_addr[9:2]] <= 1'b1;
            log_a[log_n[7:0]]         <= bus.mem_addr;
            log_d[log_n[7:0]]         <= bus.mem_din;
            log_n                     <= log_n + 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        dram_clr = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h10;
        bus.wr_data  = 32'h77;
        @(negedge clk);
        #1;
        vec++;
        if (bus.wr_ready !== 1'b1 || bus.empty !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold: rdy=%b empty=%b we=%b want 1 1 0",
                     bus.wr_ready, bus.empty, bus.mem_we);
        end
        vec++;
        if (bus.count !== 3'd0 || bus.rd_hit !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold_cnt: count=%0d hit=%b want 0 0", bus.count, bus.rd_hit);
        end
        cyc();
        cyc();
        rst = 1'b0;
        dram_clr = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        vec++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL rst_after: count=%0d empty=%b want 0 1", bus.count, bus.empty);
        end
        vec++;
        if (bus.wr_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_after_io: rdy=%b we=%b want 1 0", bus.wr_ready, bus.mem_we);
        end
    endtask

    task automatic test_single;
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h10;
        bus.wr_data  = 32'hAA;
        #1;
        vec++;
        if (bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL single_lat: mem_we=%b want 0", bus.mem_we);
        end
        cyc();
        bus.wr_valid = 1'b0;
        #1;
        vec++;
        if (bus.count !== 3'd1 || bus.mem_we !== 1'b1) begin
            bad++;
            $display("FAIL single_q: count=%0d we=%b want 1 1", bus.count, bus.mem_we);
        end
        vec++;
        if (bus.mem_addr !== 32'h10 || bus.mem_din !== 32'hAA) begin
            bad++;
            $display("FAIL single_bus: addr=%h din=%h want 10 aa", bus.mem_addr, bus.mem_din);
        end
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        vec++;
        if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
            bad++;
            $display("FAIL single_pop: empty=%b count=%0d want 1 0", bus.empty, bus.count);
        end
        vec++;
        if (dram[4] !== 32'hAA) begin
            bad++;
            $display("FAIL single_dram: dram[10]=%h want aa", dram[4]);
        end
    endtask

    task automatic test_full;
        int base;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 32'h40 + 32'(4 * i);
            bus.wr_data  = 32'h100 + 32'(i);
            cyc();
        end
        bus.wr_valid = 1'b0;
        #1;
        vec++;
        if (bus.wr_ready !== 1'b0 || bus.count !== 3'd4) begin
            bad++;
            $display("FAIL full_state: rdy=%b count=%0d want 0 4", bus.wr_ready, bus.count);
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h80;
        bus.wr_data  = 32'hBAD;
        cyc();
        #1;
        vec++;
        if (bus.count !== 3'd4) begin
            bad++;
            $display("FAIL full_ignore: count=%0d want 4", bus.count);
        end
        base = log_n;
        bus.mem_ready = 1'b1;
        #1;
        vec++;
        if (bus.mem_addr !== 32'h40 || bus.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_head: addr=%h rdy=%b want 40 0", bus.mem_addr, bus.wr_ready);
        end
        cyc();
        bus.wr_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        vec++;
        if (bus.wr_ready !== 1'b1 || bus.count !== 3'd3) begin
            bad++;
            $display("FAIL full_nobypass: rdy=%b count=%0d want 1 3", bus.wr_ready, bus.count);
        end
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        bus.mem_ready = 1'b0;
        #1;
        vec++;
        if (bus.empty !== 1'b1 || log_n - base !== 4) begin
            bad++;
            $display("FAIL full_drain: empty=%b writes=%0d want 1 4", bus.empty, log_n - base);
        end
        for (int j = 0; j < 4; j++) begin
            vec++;
            if (log_a[base + j] !== 32'h40 + 32'(4 * j) || log_d[base + j] !== 32'h100 + 32'(j)) begin
                bad++;
                $display("FAIL full_order[%0d]: got %h/%h want %h/%h", j,
                         log_a[base + j], log_d[base + j], 32'h40 + 32'(4 * j), 32'h100 + 32'(j));
            end
        end
    endtask

    task automatic test_forward;
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h20;
        bus.wr_data  = 32'h1;
        cyc();
        bus.wr_data  = 32'h2;
        cyc();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 32'h20;
        #1;
        vec++;
        if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'h2) begin
            bad++;
            $display("FAIL fwd_young: hit=%b data=%h want 1 2", bus.rd_hit, bus.rd_data);
        end
        vec++;
        if (bus.mem_we !== 1'b1) begin
            bad++;
            $display("FAIL fwd_drain: mem_we=%b want 1", bus.mem_we);
        end
        bus.rd_addr = 32'h24;
        #1;
        vec++;
        if (bus.rd_hit !== 1'b0 || bus.rd_data !== 32'hD000_0024) begin
            bad++;
            $display("FAIL fwd_miss: hit=%b data=%h want 0 d0000024", bus.rd_hit, bus.rd_data);
        end
        vec++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h24) begin
            bad++;
            $display("FAIL fwd_mux: we=%b addr=%h want 0 24", bus.mem_we, bus.mem_addr);
        end
        bus.rd_en     = 1'b0;
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        vec++;
        if (bus.empty !== 1'b1 || dram[8] !== 32'h2) begin
            bad++;
            $display("FAIL fwd_final: empty=%b dram[20]=%h want 1 2", bus.empty, dram[8]);
        end
    endtask

    task automatic test_same_cycle;
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h30;
        bus.wr_data  = 32'h55;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 32'h30;
        #1;
        vec++;
        if (bus.rd_hit !== 1'b0) begin
            bad++;
            $display("FAIL same_now: rd_hit=%b want 0", bus.rd_hit);
        end
        cyc();
        bus.wr_valid = 1'b0;
        #1;
        vec++;
        if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'h55) begin
            bad++;
            $display("FAIL same_next: hit=%b data=%h want 1 55", bus.rd_hit, bus.rd_data);
        end
        bus.rd_addr   = 32'h34;
        bus.mem_ready = 1'b1;
        #1;
        vec++;
        if (bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL stall_we: mem_we=%b want 0", bus.mem_we);
        end
        cyc();
        #1;
        vec++;
        if (bus.count !== 3'd1) begin
            bad++;
            $display("FAIL stall_cnt: count=%0d want 1", bus.count);
        end
        bus.rd_en = 1'b0;
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        vec++;
        if (bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL stall_done: empty=%b want 1", bus.empty);
        end
    endtask

    task automatic test_stream;
        int          mc;
        int          base;
        int          k;
        bit          acc;
        bit          pp;
        logic [31:0] pa[$];
        logic [31:0] pd[$];
        logic [31:0] gold [0:6];
        bit          gv [0:6];
        idle();
        mc   = 0;
        base = log_n;
        for (int j = 0; j < 7; j++) gv[j] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.wr_valid  = (i % 3 != 2);
            bus.wr_addr   = 32'h200 + 32'(4 * (i % 7));
            bus.wr_data   = 32'h6000 + 32'(i);
            bus.mem_ready = (i % 5 != 4);
            #1;
            vec++;
            if (bus.wr_ready !== (mc < DEPTH) || bus.mem_we !== (mc > 0)) begin
                bad++;
                $display("FAIL stream_io[%0d]: rdy=%b we=%b want %b %b", i,
                         bus.wr_ready, bus.mem_we, mc < DEPTH, mc > 0);
            end
            acc = bus.wr_valid && (mc < DEPTH);
            pp  = (mc > 0) && bus.mem_ready;
            if (acc) begin
                pa.push_back(bus.wr_addr);
                pd.push_back(bus.wr_data);
            end
            mc = mc + int'(acc) - int'(pp);
            cyc();
        end
        bus.wr_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        k = 0;
        while (bus.count !== 3'd0 && k < 20) begin
            cyc();
            k++;
        end
        bus.mem_ready = 1'b0;
        #1;
        vec++;
        if (bus.empty !== 1'b1 || log_n - base !== pa.size()) begin
            bad++;
            $display("FAIL stream_drain: empty=%b writes=%0d want 1 %0d",
                     bus.empty, log_n - base, pa.size());
        end
        for (int j = 0; j < pa.size(); j++) begin
            vec++;
            if (log_a[base + j] !== pa[j] || log_d[base + j] !== pd[j]) begin
                bad++;
                $display("FAIL stream_order[%0d]: got %h/%h want %h/%h", j,
                         log_a[base + j], log_d[base + j], pa[j], pd[j]);
            end
            gold[(pa[j] - 32'h200) >> 2] = pd[j];
            gv[(pa[j] - 32'h200) >> 2]   = 1'b1;
        end
        for (int j = 0; j < 7; j++) begin
            if (gv[j]) begin
                vec++;
                if (dram[8'h80 + 8'(j)] !== gold[j]) begin
                    bad++;
                    $display("FAIL stream_dram[%0d]: got %h want %h", j,
                             dram[8'h80 + 8'(j)], gold[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 32'h300 + 32'(4 * i);
            bus.wr_data  = 32'h900 + 32'(i);
            cyc();
        end
        bus.wr_valid = 1'b0;
        #1;
        vec++;
        if (bus.count !== 3'd3) begin
            bad++;
            $display("FAIL rmid_fill: count=%0d want 3", bus.count);
        end
        base = log_n;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        vec++;
        if (bus.mem_we !== 1'b0 || bus.count !== 3'd0) begin
            bad++;
            $display("FAIL rmid_hold: we=%b count=%0d want 0 0", bus.mem_we, bus.count);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vec++;
            if (bus.mem_we !== 1'b0) begin
                bad++;
                $display("FAIL rmid_we[%0d]: mem_we=%b want 0", i, bus.mem_we);
            end
            cyc();
        end
        vec++;
        if (log_n !== base || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL rmid_none: writes=%0d empty=%b want 0 1", log_n - base, bus.empty);
        end
    endtask

    initial begin
        vec = 0;
        bad = 0;
        rst = 1'b1;
        dram_clr = 1'b1;
        idle();
        test_reset();
        test_single();
        test_full();
        test_forward();
        test_same_cycle();
        test_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
